// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divisor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  // Widest operand the negation helper can handle.
  localparam int MAX_W = 64;

  // Iteration counter width: holds WIDTH/UNROLL-1 with room to spare.
  function automatic int cnt_w(input int width, input int unroll);
    return $clog2(width / unroll) + 1;
  endfunction

  // Two's-complement negation confined to the low 'width' bits.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] value,
                                                input int width);
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    return (~value + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/divisor_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract,
// keep the difference when it does not go negative.
module divisor_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] wide;

  // Trial subtraction; the remainder stays below the divisor so the
  // restored value always fits back in WIDTH+1 bits.
  always_comb begin
    wide    = {rem_in, bit_in};
    q_bit   = (wide >= (WIDTH+2)'(dvs));
    rem_out = q_bit ? (WIDTH+1)'(wide - (WIDTH+2)'(dvs)) : (WIDTH+1)'(wide);
  end

endmodule

// File: rtl/divisor_seq_param.sv
// Multi-cycle restoring divider, UNROLL quotient bits per CALC cycle,
// optional signed mode, valid/ready on both sides.
module divisor_seq_param
  import divisor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int UNROLL    = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = cnt_w(WIDTH, UNROLL);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("divisor_seq_param: WIDTH must be in 2..64");
  end
  if (UNROLL < 1 || (WIDTH % UNROLL) != 0) begin : g_bad_unroll
    $error("divisor_seq_param: WIDTH must be a multiple of UNROLL");
  end

  state_t state, state_n;

  logic [WIDTH-1:0] dd_q, dv_q;     // captured operands
  logic             mode_q;         // effective signed mode
  logic             sign_q, sign_r; // result sign fixups
  logic [WIDTH:0]   rem_q;          // partial remainder
  logic [WIDTH-1:0] sh_q;           // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvm_q;          // divisor magnitude
  logic [CW-1:0]    cnt_q;

  logic             dd_neg, dv_neg;
  logic [WIDTH-1:0] dd_mag, dv_mag;

  assign dd_neg = mode_q & dd_q[WIDTH-1];
  assign dv_neg = mode_q & dv_q[WIDTH-1];
  assign dd_mag = dd_neg ? WIDTH'(twos_neg(MAX_W'(dd_q), WIDTH)) : dd_q;
  assign dv_mag = dv_neg ? WIDTH'(twos_neg(MAX_W'(dv_q), WIDTH)) : dv_q;

  // Chain of UNROLL restoring steps evaluated each CALC cycle.
  logic [UNROLL:0][WIDTH:0]   rem_c;
  logic [UNROLL:0][WIDTH-1:0] sh_c;
  logic [UNROLL-1:0]          qb;

  assign rem_c[0] = rem_q;
  assign sh_c[0]  = sh_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    divisor_step #(.WIDTH(WIDTH)) u_step (
      .rem_in (rem_c[j]),
      .bit_in (sh_c[j][WIDTH-1]),
      .dvs    (dvm_q),
      .rem_out(rem_c[j+1]),
      .q_bit  (qb[j])
    );
    assign sh_c[j+1] = {sh_c[j][WIDTH-2:0], qb[j]};
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state: divide-by-zero skips straight from PREP to DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = PREP;
      PREP:    state_n = (dv_q == '0) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture, prepare magnitudes, iterate, fix signs, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dd_q        <= '0;
      dv_q        <= '0;
      mode_q      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      rem_q       <= '0;
      sh_q        <= '0;
      dvm_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dd_q   <= dividend;
            dv_q   <= divisor;
            mode_q <= signed_mode & (SIGNED_EN != 0);
          end
        end
        PREP: begin
          if (dv_q == '0) begin
            quotient    <= '1;
            remainder   <= dd_q;
            div_by_zero <= 1'b1;
          end else begin
            sign_q <= dd_neg ^ dv_neg;
            sign_r <= dd_neg;
            rem_q  <= '0;
            sh_q   <= dd_mag;
            dvm_q  <= dv_mag;
            cnt_q  <= CW'(STEPS - 1);
          end
        end
        CALC: begin
          rem_q <= rem_c[UNROLL];
          sh_q  <= sh_c[UNROLL];
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          quotient    <= sign_q ? WIDTH'(twos_neg(MAX_W'(sh_q), WIDTH)) : sh_q;
          remainder   <= sign_r ? WIDTH'(twos_neg(MAX_W'(rem_q[WIDTH-1:0]), WIDTH))
                                : rem_q[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        DONE: begin
          if (out_ready) div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_seq_param.sv
// Scoreboard bench for divisor_seq_param: an 8-bit signed-capable instance
// and a 16-bit, 2-bits-per-cycle unsigned-only instance.
module tb_divisor_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_in_valid = 0, a_in_ready, a_sm = 0, a_out_valid, a_out_ready = 0;
  logic       a_dz, a_busy;
  logic [7:0] a_dd = 0, a_dv = 0, a_q, a_r;

  logic        b_in_valid = 0, b_in_ready, b_sm = 0, b_out_valid, b_out_ready = 0;
  logic        b_dz, b_busy;
  logic [15:0] b_dd = 0, b_dv = 0, b_q, b_r;

  divisor_seq_param #(.WIDTH(8), .UNROLL(1), .SIGNED_EN(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .signed_mode(a_sm), .dividend(a_dd), .divisor(a_dv),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .quotient(a_q),
    .remainder(a_r), .div_by_zero(a_dz), .busy(a_busy)
  );

  divisor_seq_param #(.WIDTH(16), .UNROLL(2), .SIGNED_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .signed_mode(b_sm), .dividend(b_dd), .divisor(b_dv),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .quotient(b_q),
    .remainder(b_r), .div_by_zero(b_dz), .busy(b_busy)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference model using native integer division.
  function automatic exp_t model(input logic [15:0] dd, input logic [15:0] dv,
                                 input logic sm, input int w, input int steps);
    exp_t e;
    int   mask, sd, sv, q, r;
    mask = (1 << w) - 1;
    if ((int'(dv) & mask) == 0) begin
      e.q = 16'(mask); e.r = dd; e.dz = 1'b1; e.lat = 1;
      return e;
    end
    e.dz = 1'b0; e.lat = steps + 2;
    if (sm) begin
      sd = dd[w-1] ? int'(dd) - (1 << w) : int'(dd);
      sv = dv[w-1] ? int'(dv) - (1 << w) : int'(dv);
      if (sd == -(1 << (w-1)) && sv == -1) begin q = sd; r = 0; end
      else begin q = sd / sv; r = sd % sv; end
    end else begin
      q = int'(dd) / int'(dv);
      r = int'(dd) % int'(dv);
    end
    e.q = 16'(q & mask);
    e.r = 16'(r & mask);
    return e;
  endfunction

  // Present one operation to dut_a and push its expected result.
  task automatic start_a(input logic [7:0] dd, input logic [7:0] dv, input logic sm);
    qa.push_back(model(16'(dd), 16'(dv), sm, 8, 8));
    vecs++;
    if (a_in_ready !== 1'b1) begin
      errs++; $display("FAIL a_accept_ready: in_ready=%b want 1", a_in_ready);
    end
    a_dd = dd; a_dv = dv; a_sm = sm; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_dd = 8'($urandom); a_dv = 8'($urandom); a_sm = 1'($urandom);
  endtask

  task automatic start_b(input logic [15:0] dd, input logic [15:0] dv, input logic sm);
    qb.push_back(model(dd, dv, 1'b0, 16, 8)); // SIGNED_EN=0 ignores sm
    b_dd = dd; b_dv = dv; b_sm = sm; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_dd = 16'($urandom); b_dv = 16'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_a(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (a_out_valid !== 1'b1 && lat < 100);
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (b_out_valid !== 1'b1 && lat < 100);
  endtask

  task automatic release_a();
    a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #1 rst = 1'b0; #10;
    vecs++;
    if (a_q !== 8'h00 || a_r !== 8'h00 || a_dz !== 1'b0 || a_out_valid !== 1'b0 ||
        a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_a: q=%h r=%h dz=%b ov=%b busy=%b ir=%b want 00 00 0 0 0 1",
               a_q, a_r, a_dz, a_out_valid, a_busy, a_in_ready);
    end
    vecs++;
    if (b_q !== 16'h0 || b_r !== 16'h0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_b: q=%h r=%h ov=%b ir=%b want 0000 0000 0 1",
               b_q, b_r, b_out_valid, b_in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [7:0] dds[8] = '{8'h7F, 8'hF9, 8'h80, 8'hFF, 8'h07, 8'h81, 8'h05, 8'hFF};
    logic [7:0] dvs[8] = '{8'h05, 8'h02, 8'hFF, 8'h01, 8'hFE, 8'h07, 8'h09, 8'h10};
    logic       sms[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      start_a(dds[i], dvs[i], sms[i]);
      wait_a(lat);
      e = qa.pop_front();
      vecs++;
      if (lat !== e.lat) begin
        errs++; $display("FAIL arith_lat[%0d]: %0d edges want %0d", i, lat, e.lat);
      end
      vecs++;
      if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_dz !== e.dz) begin
        errs++;
        $display("FAIL arith[%0d] %h/%h sm=%b: q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, dds[i], dvs[i], sms[i], a_q, a_r, a_dz, e.q[7:0], e.r[7:0], e.dz);
      end
      release_a();
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] dds[3] = '{8'h7F, 8'h80, 8'h0C};
    logic [7:0] dvs[3] = '{8'h00, 8'h00, 8'h04};
    logic       sms[3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      start_a(dds[i], dvs[i], sms[i]);
      wait_a(lat);
      e = qa.pop_front();
      vecs++;
      if (lat !== e.lat || a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_dz !== e.dz) begin
        errs++;
        $display("FAIL dz[%0d]: lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
                 i, lat, a_q, a_r, a_dz, e.lat, e.q[7:0], e.r[7:0], e.dz);
      end
      release_a();
      vecs++;
      if (a_dz !== 1'b0 || a_out_valid !== 1'b0) begin
        errs++; $display("FAIL dz_clear[%0d]: dz=%b ov=%b want 0 0", i, a_dz, a_out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    start_a(8'h64, 8'h07, 1'b0);
    wait_a(lat);
    e = qa.pop_front();
    vecs++;
    if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || lat !== e.lat) begin
      errs++;
      $display("FAIL bp_first: q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
               a_q, a_r, lat, e.q[7:0], e.r[7:0], e.lat);
    end
    // Second request held while the first result is stalled.
    qa.push_back(model(16'h002D, 16'h0004, 1'b0, 8, 8));
    a_dd = 8'h2D; a_dv = 8'h04; a_sm = 1'b0; a_in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      vecs++;
      if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_out_valid !== 1'b1 ||
          a_in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold[%0d]: q=%h r=%h ov=%b ir=%b want q=%h r=%h ov=1 ir=0",
                 c, a_q, a_r, a_out_valid, a_in_ready, e.q[7:0], e.r[7:0]);
      end
    end
    a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
    vecs++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_release: ir=%b ov=%b want 1 0", a_in_ready, a_out_valid);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_a(lat);
    e = qa.pop_front();
    vecs++;
    if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_dz !== e.dz || lat !== e.lat) begin
      errs++;
      $display("FAIL bp_second: q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
               a_q, a_r, a_dz, lat, e.q[7:0], e.r[7:0], e.dz, e.lat);
    end
    release_a();
  endtask

  task automatic test_wide();
    logic [15:0] dds[3] = '{16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] dvs[3] = '{16'h0003, 16'h0007, 16'h0000};
    int lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      start_b(dds[i], dvs[i], 1'b1);
      wait_b(lat);
      e = qb.pop_front();
      vecs++;
      if (lat !== e.lat || b_q !== e.q || b_r !== e.r || b_dz !== e.dz) begin
        errs++;
        $display("FAIL wide[%0d] %h/%h: lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
                 i, dds[i], dvs[i], lat, b_q, b_r, b_dz, e.lat, e.q, e.r, e.dz);
      end
      b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_t e;
    start_a(8'hC8, 8'h03, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    void'(qa.pop_back()); // aborted operation never produces a result
    vecs++;
    if (a_q !== 8'h00 || a_r !== 8'h00 || a_dz !== 1'b0 || a_out_valid !== 1'b0 ||
        a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid: q=%h r=%h dz=%b ov=%b busy=%b ir=%b want 00 00 0 0 0 1",
               a_q, a_r, a_dz, a_out_valid, a_busy, a_in_ready);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    start_a(8'h64, 8'h0A, 1'b0);
    wait_a(lat);
    e = qa.pop_front();
    vecs++;
    if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_dz !== e.dz || lat !== e.lat) begin
      errs++;
      $display("FAIL reset_mid_next: q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
               a_q, a_r, a_dz, lat, e.q[7:0], e.r[7:0], e.dz, e.lat);
    end
    release_a();
  endtask

  task automatic test_random();
    logic [7:0] dd, dv;
    logic       sm;
    int lat;
    exp_t e;
    for (int i = 0; i < 30; i++) begin
      dd = 8'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sm = 1'($urandom);
      start_a(dd, dv, sm);
      wait_a(lat);
      e = qa.pop_front();
      vecs++;
      if (a_q !== e.q[7:0] || a_r !== e.r[7:0] || a_dz !== e.dz || lat !== e.lat) begin
        errs++;
        $display("FAIL rand[%0d] %h/%h sm=%b: q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 i, dd, dv, sm, a_q, a_r, a_dz, lat, e.q[7:0], e.r[7:0], e.dz, e.lat);
      end
      release_a();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_backpressure();
    test_wide();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/divisor_seq_param.md
Name: divisor_seq_param

Overview:
Parametrised, multi-cycle restoring integer divider. It is the next-generation arithmetic core behind the keypad/seven-segment divider top level.
- Generalised operand width and bits-per-cycle.
- Runtime signed/unsigned mode.
- Divide-by-zero flag.
- Valid/ready handshakes on both the operand side and the result side.
- Sits between the keypad operand-entry logic and the display formatter.

Parameters:
WIDTH, 8, operand/result width in bits (≥2).
UNROLL, 1, quotient bits resolved per CALC cycle; WIDTH % UNROLL must be 0 (elaboration error otherwise).
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands (high only in IDLE)
signed_mode  in  1  1 = two's-complement operands, sampled with operands
dividend  in  WIDTH  numerator
divisor  in  WIDTH  denominator
out_valid  out  1  result available (high only in DONE)
out_ready  in  1  consumer accepts result
quotient  out  WIDTH  result quotient
remainder  out  WIDTH  result remainder
div_by_zero  out  1  result produced from divisor == 0
busy  out  1  high in any state except IDLE

Behaviour:
Reset (rst low, asynchronous):
- State goes to IDLE.
- quotient, remainder, div_by_zero, out_valid and busy are all 0; in_ready is 1 after reset.
- Reset asserted mid-operation aborts the operation; no partial result is ever presented.

States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid is high on a rising edge:
  - Capture operands and the effective mode: signed_mode & SIGNED_EN.
  - Move to PREP.
- PREP (1 cycle):
  - If divisor==0, go to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Otherwise convert operands to magnitudes (signed mode), record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), clear the partial remainder, load the shift register, and go to CALC.
- CALC:
  - Each cycle performs UNROLL restoring steps: shift, trial-subtract, keep the difference if it is non-negative, and set the quotient bit.
  - Iteration counter runs from WIDTH/UNROLL−1 down to 0; at 0, go to FIX.
- FIX (1 cycle):
  - In signed mode, negate quotient if sign_q and negate remainder if sign_r.
  - Register the outputs, go to DONE.
- DONE: out_valid=1; outputs held stable while out_ready is low. When out_ready is high on an edge, go to IDLE and drop out_valid.

Latency:
- out_valid rises WIDTH/UNROLL + 2 edges after the accepting edge.
- For divide-by-zero, out_valid rises 1 edge after the accepting edge.
- Throughput: one operation per latency + 1 cycles (one IDLE cycle between results; no overlap).

Arithmetic rules:
- Partial remainder is WIDTH+1 bits wide.
- Signed results truncate toward zero; the remainder takes the dividend's sign.
- Invariant: dividend = quotient·divisor + remainder.
- Signed most-negative ÷ −1 wraps: quotient = most-negative value, remainder = 0, no flag.
- Unsigned mode treats the MSB as magnitude.

Handshake corner cases:
- in_valid while busy is ignored; the producer must hold its operands.
- Operand inputs are don't-care outside the accepting edge.
- out_ready high while out_valid is low has no effect.
- div_by_zero is valid only while out_valid is high, and is cleared on leaving DONE.

Decomposition:
- Package divisor_pkg holds:
  - state_t enum (IDLE, PREP, CALC, FIX, DONE);
  - localparam helpers for the counter width, $clog2(WIDTH/UNROLL)+1;
  - function twos_neg(value, width) for negation.
- One natural sub-module: divisor_step, a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
  - Instantiated UNROLL times in a chain inside the CALC datapath.

Test Plan:
1. WIDTH=8, unsigned, 0x7F / 0x05 → quotient 0x19, remainder 0x02, div_by_zero 0, out_valid 10 edges after accept.
2. WIDTH=8, signed, 0xF9 (−7) / 0x02 → quotient 0xFD (−3), remainder 0xFF (−1); then 0x80 / 0xFF → quotient 0x80, remainder 0x00.
3. 0x7F / 0x00 → quotient 0xFF, remainder 0x7F, div_by_zero 1, out_valid 1 edge after accept; next operation clears the flag.
4. Backpressure: hold out_ready low 20 cycles after out_valid → outputs stable, in_ready 0, a second in_valid is ignored; release → IDLE next edge, second operation then accepted.
5. WIDTH=16, UNROLL=2, unsigned 0xFFFF / 0x0003 → quotient 0x5555, remainder 0x0000, out_valid 10 edges after accept.
6. Drive rst low during the 4th CALC cycle → all outputs 0 and in_ready 1 immediately (asynchronous); a new 0x64 / 0x0A after release → quotient 0x0A, remainder 0x00.
